// File: rtl/dmem_write_buffer_pkg.sv
// Shared types and constants for the data-memory write buffer.
// Defines the entry struct, bus widths and a pointer-width helper.
package dmem_pkg;

    localparam int WB_ADDR_W = 9;
    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Pointer width for a circular buffer of the given depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_write_buffer_if.sv
// Cache/memory-side bus of the write buffer.
// slave: the buffer; master: the cache and data memory around it.
interface dmem_write_buffer_if;
    import dmem_pkg::*;

    logic                 wr_valid;
    logic                 wr_ready;
    logic [WB_ADDR_W-1:0] wr_addr;
    logic [WB_DATA_W-1:0] wr_data;
    logic [WB_ADDR_W-1:0] rd_addr;
    logic                 rd_hit;
    logic [WB_DATA_W-1:0] rd_data;
    logic                 mem_req;
    logic [WB_ADDR_W-1:0] mem_addr;
    logic [WB_DATA_W-1:0] mem_wdata;
    logic                 mem_ack;
    logic                 empty;
    logic                 full;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_addr, mem_ack,
        output wr_ready, rd_hit, rd_data,
        output mem_req, mem_addr, mem_wdata,
        output empty, full
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_addr, mem_ack,
        input  wr_ready, rd_hit, rd_data,
        input  mem_req, mem_addr, mem_wdata,
        input  empty, full
    );

endinterface

// File: rtl/dmem_write_buffer_match.sv
// Address compare over all buffer entries, walked oldest to youngest.
// Ports: ent_i entries, key_i address, head_i oldest slot,
//        skip_head_i ignore head, hit_o any match, idx_o youngest match.
module wb_match
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  wb_entry_t            ent_i [DEPTH],
    input  logic [WB_ADDR_W-1:0] key_i,
    input  logic [PW-1:0]        head_i,
    input  logic                 skip_head_i,
    output logic                 hit_o,
    output logic [PW-1:0]        idx_o
);

    logic [PW-1:0] p;

    // Later (younger) matches override earlier ones.
    always_comb begin
        hit_o = 1'b0;
        idx_o = head_i;
        p     = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            p = head_i + PW'(k);
            if (ent_i[p].valid &&
                ent_i[p].addr == key_i &&
                !(skip_head_i && k == 0)) begin
                hit_o = 1'b1;
                idx_o = p;
            end
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-write FIFO between L1 D-cache and data memory, with
// coalescing and load forwarding. Ports: clk, rst, bus (slave side).
module dmem_write_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    dmem_write_buffer_if.slave bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    wb_entry_t ent_q [DEPTH];
    wb_entry_t ent_d [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   cnt_q, cnt_d;

    logic full, empty;
    logic accept, push, pop;

    logic          rd_hit;
    logic [PW-1:0] rd_idx;
    logic          co_hit;
    logic [PW-1:0] co_idx;

    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] fwd_data;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

    // Forwarding: youngest match, head included.
    wb_match #(.DEPTH(DEPTH)) u_rd_match (
        .ent_i       (ent_q),
        .key_i       (bus.rd_addr),
        .head_i      (head_q),
        .skip_head_i (1'b0),
        .hit_o       (rd_hit),
        .idx_o       (rd_idx)
    );

    // Coalescing: head is in flight, so never merge into it.
    wb_match #(.DEPTH(DEPTH)) u_co_match (
        .ent_i       (ent_q),
        .key_i       (bus.wr_addr),
        .head_i      (head_q),
        .skip_head_i (1'b1),
        .hit_o       (co_hit),
        .idx_o       (co_idx)
    );

    assign accept = bus.wr_valid && !full;
    assign push   = accept && !co_hit;
    assign pop    = !empty && bus.mem_ack;

    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (pop) begin
            ent_d[head_q].valid = 1'b0;
            head_d = head_q + PW'(1);
        end
        if (accept) begin
            if (co_hit) begin
                ent_d[co_idx].data = bus.wr_data;
            end else begin
                ent_d[tail_q].valid = 1'b1;
                ent_d[tail_q].addr  = bus.wr_addr;
                ent_d[tail_q].data  = bus.wr_data;
                tail_d = tail_q + PW'(1);
            end
        end
        cnt_d = cnt_q + {{PW{1'b0}}, push}
                      - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent_q  <= ent_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Zero the memory-side bus whenever nothing is queued.
    always_comb begin
        head_addr = '0;
        head_data = '0;
        if (!empty) begin
            head_addr = ent_q[head_q].addr;
            head_data = ent_q[head_q].data;
        end
    end

    always_comb begin
        fwd_data = '0;
        if (rd_hit) begin
            fwd_data = ent_q[rd_idx].data;
        end
    end

    assign bus.wr_ready  = !full;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.mem_req   = !empty;
    assign bus.mem_addr  = head_addr;
    assign bus.mem_wdata = head_data;
    assign bus.rd_hit    = rd_hit;
    assign bus.rd_data   = fwd_data;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Self-checking bench for dmem_write_buffer: directed steps, then
// random traffic, all compared against a queue-based reference model.
module tb_dmem_write_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [8:0]  a;
        logic [31:0] d;
    } ment_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   armed    = 0;
    ment_t q[$];

    always #5 clk = ~clk;

    dmem_write_buffer_if bus ();

    dmem_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check at negedge, update model at posedge.
    task automatic cyc(input bit wv, input logic [8:0] wa,
                       input logic [31:0] wd, input logic [8:0] ra,
                       input bit ack, input bit r);
        bit          hit;
        logic [31:0] rdat;
        int          n;
        int          ci;
        bit          fl;
        bus.wr_valid = wv;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_addr  = ra;
        bus.mem_ack  = ack;
        rst          = r;
        @(negedge clk);
        n    = q.size();
        hit  = 0;
        rdat = 0;
        foreach (q[i]) begin
            if (q[i].a == ra) begin
                hit  = 1;
                rdat = q[i].d;
            end
        end
        fl = (n == DEPTH);
        if (armed) begin
            check("flags",
                  {59'd0, bus.empty, bus.full, bus.wr_ready,
                   bus.mem_req, bus.rd_hit},
                  {59'd0, n == 0, fl, !fl, n != 0, hit});
            check("mem_addr", 64'(bus.mem_addr),
                  64'(n != 0 ? q[0].a : 9'd0));
            check("mem_wdata", 64'(bus.mem_wdata),
                  64'(n != 0 ? q[0].d : 32'd0));
            check("rd_data", 64'(bus.rd_data), 64'(rdat));
        end
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (wv && !fl) begin
                ci = -1;
                for (int i = 1; i < n; i++) begin
                    if (q[i].a == wa) ci = i;
                end
                if (ci >= 0) q[ci].d = wd;
                else q.push_back('{a: wa, d: wd});
            end
            if (n != 0 && ack) void'(q.pop_front());
        end
        #1;
    endtask

    task automatic st(input logic [8:0] a, input logic [31:0] d,
                      input bit ack);
        cyc(1, a, d, a, ack, 0);
    endtask

    task automatic idle(input int k, input logic [8:0] ra,
                        input bit ack);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, ra, ack, 0);
    endtask

    initial begin
        bus.wr_valid = 0;
        bus.wr_addr  = 0;
        bus.wr_data  = 0;
        bus.rd_addr  = 0;
        bus.mem_ack  = 0;
        cyc(0, 0, 0, 0, 0, 1);
        armed = 1;
        idle(2, 9'h000, 0);

        st(9'h010, 32'hDEADBEEF, 0);
        idle(5, 9'h010, 0);
        idle(1, 9'h010, 1);
        idle(2, 9'h010, 0);

        st(9'h001, 32'h11, 0);
        st(9'h002, 32'h22, 0);
        st(9'h003, 32'h33, 0);
        st(9'h004, 32'h44, 0);
        st(9'h005, 32'h55, 0);
        st(9'h006, 32'h66, 1);
        idle(4, 9'h004, 1);
        st(9'h005, 32'h55, 0);
        idle(1, 9'h005, 1);
        idle(1, 9'h005, 0);

        st(9'h020, 32'd1, 0);
        st(9'h030, 32'd2, 0);
        st(9'h030, 32'd3, 0);
        idle(1, 9'h030, 0);
        idle(1, 9'h040, 0);
        idle(3, 9'h030, 1);

        st(9'h050, 32'd7, 0);
        st(9'h050, 32'd8, 0);
        idle(1, 9'h050, 1);
        idle(2, 9'h050, 1);

        st(9'h061, 32'hA, 0);
        st(9'h062, 32'hB, 0);
        st(9'h063, 32'hC, 0);
        idle(1, 9'h062, 1);
        cyc(0, 0, 0, 9'h063, 0, 1);
        idle(2, 9'h063, 1);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 1) == 1,
                9'($urandom_range(0, 7)),
                $urandom,
                9'($urandom_range(0, 7)),
                $urandom_range(0, 9) < 4,
                $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
